mux_share_arbiter: RTL and testbench

Sequencer that shares the gate-level 2:1 `mux` (data inputs `a`/`b`, control `select`) between two requesters. It arbitrates with round-robin priority, drives the mux select, and holds each grant for a fixed burst of cycles. The selected data bit is registered onto a single shared output line. It sits directly in front of the `mux` instance and owns its `select` pin; no other block drives `select`.

---
 rtl/mux_share_arbiter.sv | 55 +++++
 tb/tb_mux_share_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin burst arbiter owning the shared 2:1 mux select, with registered shared output.
// Optional MUX_SHARE_ARB_FIXED_PRIO_EN: requester 0 always wins ties and no last-winner register is built.
module mux_share_arbiter #(
  parameter int BURST = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          a,
  input  logic          b,
  output logic          sel,
  output logic          gnt0,
  output logic          gnt1,
  output logic          s,
  output logic          busy,
  output logic [CW-1:0] cnt
);
  localparam logic [1:0] IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2, GAP = 2'd3;
  logic [1:0] state, nxt;
  logic pick1, done, in_grant, stay;
  assign in_grant = ^state;
  assign done = cnt == CW'(BURST - 1);
  assign stay = in_grant && nxt == state;
`ifdef MUX_SHARE_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  logic last;
  assign pick1 = req1 & (~req0 | ~last);
  always_ff @(posedge clk)
    if (!rst_n) last <= 1'b1;
    else if (in_grant && nxt == GAP) last <= state[1];
`endif
  always_comb
    nxt = state == IDLE   ? ((req0 | req1) ? (pick1 ? GRANT1 : GRANT0) : IDLE) :
          state == GRANT0 ? ((done | ~req0) ? GAP : GRANT0) :
          state == GRANT1 ? ((done | ~req1) ? GAP : GRANT1) : IDLE;
  // s carries the mux output sampled one cycle earlier, only while the same grant continues
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= 1'b0;
      s     <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= stay ? cnt + 1'b1 : '0;
      sel   <= nxt == GRANT1 ? 1'b1 : nxt == GRANT0 ? 1'b0 : sel;
      s     <= stay ? (sel ? b : a) : 1'b0;
    end
  assign gnt0 = state == GRANT0;
  assign gnt1 = state == GRANT1;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: directed checks of reset, bursts, ties, early release, BURST=1, plus random invariant sweep.
module tb_mux_share_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0, a = 1'b0, b = 1'b0;
  logic sel, gnt0, gnt1, s, busy, sel1, g10, g11, s1, busy1;
  logic [2:0] cnt, cnt1;
  logic [7:0] o, o1;
  int checks = 0, failures = 0;
  logic [7:0] tie_exp [13];
  always #5 clk = ~clk;
  mux_share_arbiter #(.BURST(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .a(a), .b(b),
    .sel(sel), .gnt0(gnt0), .gnt1(gnt1), .s(s), .busy(busy), .cnt(cnt));
  mux_share_arbiter #(.BURST(1), .CW(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .a(a), .b(b),
    .sel(sel1), .gnt0(g10), .gnt1(g11), .s(s1), .busy(busy1), .cnt(cnt1));
  // packed view: {gnt0, gnt1, sel, s, busy, cnt[2:0]}
  assign o  = {gnt0, gnt1, sel, s, busy, cnt};
  assign o1 = {g10, g11, sel1, s1, busy1, cnt1};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  initial begin
    logic pg, psel;
    tie_exp[0] = 8'b10001_000; tie_exp[1] = 8'b10001_001; tie_exp[2] = 8'b10001_010;
    tie_exp[3] = 8'b10001_011; tie_exp[4] = 8'b00001_000; tie_exp[5] = 8'b00000_000;
`ifdef MUX_SHARE_ARB_FIXED_PRIO_EN
    tie_exp[6] = 8'b10001_000; tie_exp[7] = 8'b10001_001; tie_exp[8] = 8'b10001_010;
    tie_exp[9] = 8'b10001_011; tie_exp[10] = 8'b00001_000; tie_exp[11] = 8'b00000_000;
`else
    tie_exp[6] = 8'b01101_000; tie_exp[7] = 8'b01111_001; tie_exp[8] = 8'b01111_010;
    tie_exp[9] = 8'b01111_011; tie_exp[10] = 8'b00101_000; tie_exp[11] = 8'b00100_000;
`endif
    tie_exp[12] = 8'b10001_000;
    step(); step();
    chk("reset", o, 8'b00000_000);
    rst_n = 1'b1; req0 = 1'b1; a = 1'b1;
    step(); chk("single_c1", o, 8'b10001_000);
    step(); chk("single_c2", o, 8'b10011_001);
    step(); chk("single_c3", o, 8'b10011_010);
    step(); chk("single_c4", o, 8'b10011_011);
    req0 = 1'b0;
    step(); chk("single_gap", o, 8'b00001_000);
    step(); chk("single_idle", o, 8'b00000_000);
    req0 = 1'b1;
    step(); chk("rst_mid_c1", o, 8'b10001_000);
    step(); chk("rst_mid_c2", o, 8'b10011_001);
    step(); chk("rst_mid_c3", o, 8'b10011_010);
    rst_n = 1'b0;
    step(); chk("rst_mid_reset", o, 8'b00000_000);
    rst_n = 1'b1; req0 = 1'b0;
    step(); chk("rst_mid_idle", o, 8'b00000_000);
    req0 = 1'b1; req1 = 1'b1; a = 1'b0; b = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      chk($sformatf("tie_%0d", i), o, tie_exp[i]);
    end
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b0;
    step(); rst_n = 1'b1;
    req1 = 1'b1; b = 1'b1; a = 1'b0;
    step(); chk("early_c1", o, 8'b01101_000);
    step(); chk("early_c2", o, 8'b01111_001);
    req1 = 1'b0;
    step(); chk("early_gap", o, 8'b00101_000);
    step(); chk("early_idle", o, 8'b00100_000);
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    req0 = 1'b1; a = 1'b1;
    step(); chk("b1_grant", o1, 8'b10001_000);
    step(); chk("b1_gap", o1, 8'b00001_000);
    step(); chk("b1_idle", o1, 8'b00000_000);
    step(); chk("b1_regrant", o1, 8'b10001_000);
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    pg = 1'b0; psel = sel;
    for (int i = 0; i < 1000; i++) begin
      req0 = 1'($urandom); req1 = 1'($urandom); a = 1'($urandom); b = 1'($urandom);
      step();
      chk("rand_mutex", {7'd0, gnt0 & gnt1}, 8'd0);
      if (pg && (gnt0 | gnt1)) chk("rand_sel_hold", {7'd0, sel}, {7'd0, psel});
      if (!pg) chk("rand_s_zero", {7'd0, s}, 8'd0);
      pg = gnt0 | gnt1; psel = sel;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
